morse_keyer: RTL

//  Buffered, timed Morse transmitter. Accepts 6-bit character codes (0-9 = digits, 10-35 = A-Z)

---
 rtl/morse_pkg.sv | 30 +++
 rtl/morse_rom.sv | 21 ++
 rtl/morse_keyer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse keyer: character table, FSM states, space code.
// `MORSE_WORDSPACE_EN adds the WGAP state used by the word-space code.
package morse_pkg;

  localparam int         NUM_CHARS  = 36;
  localparam logic [5:0] SPACE_CODE = 6'd36;

`ifdef MORSE_WORDSPACE_EN
  typedef enum logic [2:0] {IDLE, MARK, EGAP, CGAP, WGAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, MARK, EGAP, CGAP} state_t;
`endif

  // Entry = {pattern[4:0], width[2:0]}; pattern[width-1] is sent first, 1 = dash.
  localparam logic [7:0] MORSE_TABLE [NUM_CHARS] = '{
    8'b11111_101, 8'b01111_101, 8'b00111_101, 8'b00011_101, 8'b00001_101,
    8'b00000_101, 8'b10000_101, 8'b11000_101, 8'b11100_101, 8'b11110_101,
    8'b00001_010, 8'b01000_100, 8'b01010_100, 8'b00100_011, 8'b00000_001,
    8'b00010_100, 8'b00110_011, 8'b00000_100, 8'b00000_010, 8'b00111_100,
    8'b00101_011, 8'b00100_100, 8'b00011_010, 8'b00010_010, 8'b00111_011,
    8'b00110_100, 8'b01101_100, 8'b00010_011, 8'b00000_011, 8'b00001_001,
    8'b00001_011, 8'b00001_100, 8'b00011_011, 8'b01001_100, 8'b01011_100,
    8'b01100_100
  };

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational character code -> {pattern, width} lookup.
// Codes outside the table send as '0'.
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0] code,
  output logic [4:0] pat,
  output logic [2:0] width
);

  logic [7:0] entry;

  always_comb begin
    entry = MORSE_TABLE[0];
    if (code < 6'(NUM_CHARS)) entry = MORSE_TABLE[code];
  end

  assign pat   = entry[7:3];
  assign width = entry[2:0];

endmodule

// File: rtl/morse_keyer.sv
// Buffered Morse transmitter: input FIFO, table lookup and unit-timed key FSM.
// `MORSE_WORDSPACE_EN makes code 36 a word space (WGAP) instead of '0'.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES    = 5_000_000,
  parameter int DASH_UNITS     = 3,
  parameter int CHAR_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS = 7,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       key,
  output logic       busy,
  output logic       done
);

  localparam int DOT_CYC  = UNIT_CYCLES;
  localparam int DASH_CYC = DASH_UNITS * UNIT_CYCLES;
  localparam int CGAP_CYC = CHAR_GAP_UNITS * UNIT_CYCLES;
  localparam int WGAP_CYC = (WORD_GAP_UNITS - CHAR_GAP_UNITS) * UNIT_CYCLES;
  localparam int MAX_CYC  = max_int(max_int(DOT_CYC, DASH_CYC), max_int(CGAP_CYC, WGAP_CYC));
  localparam int CW       = $clog2(MAX_CYC) + 1;
  localparam int AW       = $clog2(FIFO_DEPTH);

  // Counter reload values: a state lasts N cycles when entered with N-1.
  localparam logic [CW-1:0] DOT_LD  = CW'(DOT_CYC - 1);
  localparam logic [CW-1:0] DASH_LD = CW'(DASH_CYC - 1);
  localparam logic [CW-1:0] EGAP_LD = CW'(DOT_CYC - 1);
  localparam logic [CW-1:0] CGAP_LD = CW'(CGAP_CYC - 1);
`ifdef MORSE_WORDSPACE_EN
  localparam logic [CW-1:0] WGAP_LD = CW'(WGAP_CYC - 1);
`endif

  logic [5:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          push, pop, empty, full;
  logic [5:0]    head;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

  logic [4:0] rom_pat;
  logic [2:0] rom_w, rom_last;

  morse_rom u_rom (
    .code  (head),
    .pat   (rom_pat),
    .width (rom_w)
  );

  assign rom_last = rom_w - 3'd1;

  state_t        state, state_d, start_state;
  logic [CW-1:0] cnt, cnt_d, start_cnt;
  logic [4:0]    pat, pat_d;
  logic [2:0]    idx, idx_d;
  logic          done_d;

  // First state and duration of the character at the FIFO head.
  always_comb begin
    start_state = MARK;
    start_cnt   = rom_pat[rom_last] ? DASH_LD : DOT_LD;
`ifdef MORSE_WORDSPACE_EN
    if (head == SPACE_CODE) begin
      start_state = WGAP;
      start_cnt   = WGAP_LD;
    end
`endif
  end

  always_comb begin
    state_d = state;
    cnt_d   = (cnt != '0) ? cnt - 1'b1 : cnt;
    pat_d   = pat;
    idx_d   = idx;
    pop     = 1'b0;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = start_state;
          cnt_d   = start_cnt;
          pat_d   = rom_pat;
          idx_d   = rom_last;
        end
      end
      MARK: begin
        if (cnt == '0) begin
          if (idx != 3'd0) begin
            state_d = EGAP;
            cnt_d   = EGAP_LD;
            idx_d   = idx - 1'b1;
          end else begin
            state_d = CGAP;
            cnt_d   = CGAP_LD;
          end
        end
      end
      EGAP: begin
        if (cnt == '0) begin
          state_d = MARK;
          cnt_d   = pat[idx] ? DASH_LD : DOT_LD;
        end
      end
      CGAP
`ifdef MORSE_WORDSPACE_EN
      , WGAP
`endif
      : begin
        // Last gap cycle: chain straight into the next character when one is waiting.
        if (cnt == '0) begin
          done_d = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            state_d = start_state;
            cnt_d   = start_cnt;
            pat_d   = rom_pat;
            idx_d   = rom_last;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      key   <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      key   <= (state == MARK);
      done  <= done_d;
      busy  <= (state != IDLE) || !empty;
    end
  end

  always_ff @(posedge clk) begin
    pat <= pat_d;
    idx <= idx_d;
  end

endmodule
